// File: rtl/systolic_pkg.sv
// Shared constants for the 3x3 FP32 systolic multiplier: array defaults,
// FP32 field positions and the result-drain state encoding.
package systolic_pkg;

  localparam int unsigned N_DEFAULT      = 3;
  localparam int unsigned DW_DEFAULT     = 32;
  localparam int unsigned SETTLE_DEFAULT = 12;

  // FP32 field layout
  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned EXP_W    = EXP_MSB - EXP_LSB + 1;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;

  // Result-drain state encoding
  localparam logic [1:0] DRAIN_IDLE   = 2'd0;
  localparam logic [1:0] DRAIN_SETTLE = 2'd1;
  localparam logic [1:0] DRAIN_STREAM = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = DRAIN_IDLE,
    StSettle = DRAIN_SETTLE,
    StStream = DRAIN_STREAM
  } drain_state_e;

endpackage

// File: rtl/systolic_drain_snapshot.sv
// NxN capture register file for the result drain. Loads the whole PE result
// vector in one edge and presents the word selected by idx_i.
// With DRAIN_EXC_FLAG_EN defined it also flags NaN/Inf (exponent all ones)
// on the selected word and on the vector being loaded.
module systolic_drain_snapshot
  import systolic_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned IW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [N*N*DW-1:0] res_flat_i,
  input  logic [IW-1:0]     idx_i,
  output logic [DW-1:0]     rd_data_o
`ifdef DRAIN_EXC_FLAG_EN
  ,
  output logic              rd_exc_o,
  output logic              load_exc_o
`endif
);

  logic [N*N-1:0][DW-1:0] snap_q;

  // Snapshot register: whole array captured on load, otherwise held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_q <= '0;
    end else if (load_i) begin
      snap_q <= res_flat_i;
    end
  end

  assign rd_data_o = snap_q[idx_i];

`ifdef DRAIN_EXC_FLAG_EN
  assign rd_exc_o = (rd_data_o[EXP_MSB:EXP_LSB] == EXP_ALL1);

  // Any word in the incoming vector with an all-ones exponent.
  always_comb begin
    load_exc_o = 1'b0;
    for (int k = 0; k < N * N; k++) begin
      if (res_flat_i[k*DW+EXP_LSB +: EXP_W] == EXP_ALL1) begin
        load_exc_o = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/systolic_result_drain.sv
// Reader end of the systolic multiplier: waits SETTLE_CYCLES edges after an
// accepted start, snapshots all NxN results and streams them row-major over
// valid/ready. The array is free for reuse as soon as the snapshot is taken.
// Optional feature macro: DRAIN_EXC_FLAG_EN adds out_exc / exc_any NaN/Inf flags.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int unsigned N             = N_DEFAULT,
  parameter int unsigned DW            = DW_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = SETTLE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N*N*DW-1:0] res_flat,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        out_row,
  output logic [1:0]        out_col,
  output logic              busy,
  output logic              done,
  output logic              start_drop
`ifdef DRAIN_EXC_FLAG_EN
  ,
  output logic              out_exc,
  output logic              exc_any
`endif
);

  localparam int unsigned WORDS = N * N;
  localparam int unsigned IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CntLoad = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IdxLast = IW'(WORDS - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("systolic_result_drain: SETTLE_CYCLES must be >= 1");
  end

  drain_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;
  logic          snap_load;
  logic          hs;
  logic          at_last;
  logic [DW-1:0] rd_data;
  logic [IW-1:0] row_w;
  logic [IW-1:0] col_w;

`ifdef DRAIN_EXC_FLAG_EN
  logic          exc_any_q, exc_any_d;
  logic          rd_exc;
  logic          load_exc;
`endif

  systolic_drain_snapshot #(
    .N  (N),
    .DW (DW),
    .IW (IW)
  ) u_snapshot (
    .clk        (clk),
    .reset      (reset),
    .load_i     (snap_load),
    .res_flat_i (res_flat),
    .idx_i      (idx_q),
    .rd_data_o  (rd_data)
`ifdef DRAIN_EXC_FLAG_EN
    ,
    .rd_exc_o   (rd_exc),
    .load_exc_o (load_exc)
`endif
  );

  assign hs      = out_valid & out_ready;
  assign at_last = (idx_q == IdxLast);

  // Next-state: settle countdown, capture, stream index and pulse outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    snap_load = 1'b0;
`ifdef DRAIN_EXC_FLAG_EN
    exc_any_d = exc_any_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSettle;
          cnt_d   = CntLoad;
`ifdef DRAIN_EXC_FLAG_EN
          exc_any_d = 1'b0;
`endif
        end
      end
      StSettle: begin
        drop_d = start;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          snap_load = 1'b1;
          idx_d     = '0;
          state_d   = StStream;
`ifdef DRAIN_EXC_FLAG_EN
          exc_any_d = exc_any_q | load_exc;
`endif
        end
      end
      StStream: begin
        if (hs && at_last) begin
          done_d = 1'b1;
          // A start coinciding with the final handshake is taken back-to-back.
          if (start) begin
            state_d = StSettle;
            cnt_d   = CntLoad;
`ifdef DRAIN_EXC_FLAG_EN
            exc_any_d = 1'b0;
`endif
          end else begin
            state_d = StIdle;
          end
        end else begin
          drop_d = start;
          if (hs) begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counters and pulse registers; reset aborts any drain in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

`ifdef DRAIN_EXC_FLAG_EN
  // Sticky exception flag, cleared by the next accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_any_q <= 1'b0;
    end else begin
      exc_any_q <= exc_any_d;
    end
  end

  assign out_exc = out_valid & rd_exc;
  assign exc_any = exc_any_q;
`endif

  // Outputs come straight from flops (via the snapshot read mux) and are
  // forced to zero whenever no word is being offered.
  assign row_w      = idx_q / IW'(N);
  assign col_w      = idx_q % IW'(N);
  assign out_valid  = (state_q == StStream);
  assign out_data   = out_valid ? rd_data : '0;
  assign out_row    = out_valid ? 2'(row_w) : 2'b0;
  assign out_col    = out_valid ? 2'(col_w) : 2'b0;
  assign out_last   = out_valid & at_last;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign start_drop = drop_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: timeline reference model + scoreboard.
module tb_systolic_result_drain;

  localparam int N     = 3;
  localparam int DW    = 32;
  localparam int S     = 12;
  localparam int WORDS = N * N;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                out_ready;
  logic [WORDS*DW-1:0] res_flat;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                out_last;
  logic [1:0]          out_row;
  logic [1:0]          out_col;
  logic                busy;
  logic                done;
  logic                start_drop;
`ifdef DRAIN_EXC_FLAG_EN
  logic                out_exc;
  logic                exc_any;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_result_drain #(
    .N             (N),
    .DW            (DW),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .res_flat   (res_flat),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_row    (out_row),
    .out_col    (out_col),
    .busy       (busy),
    .done       (done),
    .start_drop (start_drop)
`ifdef DRAIN_EXC_FLAG_EN
    ,
    .out_exc    (out_exc),
    .exc_any    (exc_any)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } word_t;

  word_t sb[$];

  // Reference timeline: a pending snapshot at an absolute edge number, and
  // a count of words still owed to the consumer.
  int edge_no     = 0;
  bit m_pending   = 0;
  int m_snap_edge = 0;
  int m_left      = 0;
  bit m_done      = 0;
  bit m_drop      = 0;
  bit m_exc_any   = 0;
  bit zero_chk    = 0;
  int ready_mode  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_word(input logic [1:0] r, input logic [1:0] c, input int budget,
                           input string name);
    int n = 0;
    while (!(out_valid && out_row == r && out_col == c) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!(out_valid && out_row == r && out_col == c)) begin
      errors++;
      $display("FAIL %s: word (%0d,%0d) not seen within %0d cycles", name, r, c, budget);
    end
  endtask

  task automatic rand_flat();
    for (int k = 0; k < WORDS; k++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) == 0) w[30:23] = 8'hFF;
      res_flat[k*DW +: DW] = w;
    end
  endtask

  // Consumer ready pattern: 0 always ready, 1 alternating, 2 random.
  initial begin
    out_ready = 1'b1;
    forever begin
      tick();
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model, evaluated on every active edge and on reset.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      sb.delete();
      m_pending = 0;
      m_left    = 0;
      m_done    = 0;
      m_drop    = 0;
      m_exc_any = 0;
    end else begin
      bit hs, fin, idle, acc;
      edge_no++;
      hs     = (m_left > 0) && out_ready;
      fin    = hs && (m_left == 1);
      idle   = !m_pending && (m_left == 0);
      acc    = start && (idle || fin);
      m_done = fin;
      m_drop = start && !acc;
      if (hs) m_left--;
      if (m_pending && edge_no == m_snap_edge) begin
        m_pending = 0;
        m_left    = WORDS;
        for (int k = 0; k < WORDS; k++) begin
          word_t w;
          w.data = res_flat[k*DW +: DW];
          w.row  = 2'(k / N);
          w.col  = 2'(k % N);
          w.last = (k == WORDS - 1);
          sb.push_back(w);
          if (w.data[30:23] == 8'hFF) m_exc_any = 1;
        end
      end
      if (acc) begin
        m_pending   = 1;
        m_snap_edge = edge_no + S;
        m_exc_any   = 0;
      end
    end
  end

  // Monitor: control outputs every cycle; data against the scoreboard head.
  initial forever begin
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_left > 0));
    chk("busy", 32'(busy), 32'(m_pending || m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("start_drop", 32'(start_drop), 32'(m_drop));
`ifdef DRAIN_EXC_FLAG_EN
    chk("exc_any", 32'(exc_any), 32'(m_exc_any));
    if (!out_valid) chk("out_exc_idle", 32'(out_exc), 32'd0);
`endif
    if (zero_chk) begin
      chk("idle_data", out_data, 32'd0);
      chk("idle_rowcol_last", {27'd0, out_row, out_col, out_last}, 32'd0);
    end
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected no word", out_data);
      end else begin
        word_t e;
        e = sb[0];
        chk("out_data", out_data, e.data);
        chk("out_row", 32'(out_row), 32'(e.row));
        chk("out_col", 32'(out_col), 32'(e.col));
        chk("out_last", 32'(out_last), 32'(e.last));
`ifdef DRAIN_EXC_FLAG_EN
        chk("out_exc", 32'(out_exc), 32'(e.data[30:23] == 8'hFF));
`endif
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    zero_chk = 1'b1;
    rand_flat();

    // Reset with random inputs, then idle with no start.
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    zero_chk = 1'b0;

    // Basic in-order stream, consumer always ready.
    for (int k = 0; k < WORDS; k++) res_flat[k*DW +: DW] = 32'h40000000 | k;
    ready_mode = 0;
    pulse_start();
    wait_done(40, "basic_done");
    tick();

    // Alternating ready; array output trashed right after capture.
    rand_flat();
    ready_mode = 1;
    pulse_start();
    wait_word(2'd0, 2'd0, 30, "stall_first");
    res_flat = {WORDS{32'hDEADBEEF}};
    wait_done(60, "stall_done");
    tick();

    // Dropped start during settle, then a start on the final handshake.
    rand_flat();
    ready_mode = 0;
    pulse_start();
    tick();
    tick();
    pulse_start();
    wait_word(2'd2, 2'd2, 40, "b2b_last");
    rand_flat();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wait_done(40, "b2b_done");
    tick();

    // Reset while word 4 is on the output, then a fresh full stream.
    rand_flat();
    pulse_start();
    wait_word(2'd1, 2'd1, 40, "abort_word4");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    pulse_start();
    wait_done(40, "restart_done");
    tick();

    // One NaN at PE(1,2); sticky flag until the next accepted start.
    for (int k = 0; k < WORDS; k++) res_flat[k*DW +: DW] = 32'h3F800000;
    res_flat[5*DW +: DW] = 32'h7FC00000;
    pulse_start();
    wait_done(40, "nan_done");
    repeat (3) tick();
    for (int k = 0; k < WORDS; k++) res_flat[k*DW +: DW] = 32'h3F800000;
    pulse_start();
    wait_done(40, "clean_done");
    tick();

    // Randomized traffic: random data, starts and consumer stalls.
    ready_mode = 2;
    for (int c = 0; c < 600; c++) begin
      rand_flat();
      start = ($urandom_range(0, 7) == 0);
      tick();
    end
    start = 1'b0;
    ready_mode = 0;
    begin
      int n = 0;
      while (busy && n < 100) begin
        tick();
        n++;
      end
    end
    repeat (3) tick();
    chk("drain_idle", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
